vpu_d2h_rsp_gen: RTL and testbench

//  Device-to-host completion responder; the return end of the H2D instruction path.

---
 rtl/vpu_d2h_rsp_gen_pkg.sv | 67 ++++++
 rtl/vpu_sync_fifo.sv | 82 ++++++++
 rtl/vpu_d2h_rsp_gen.sv | 179 +++++++++++++++++
 tb/tb_vpu_d2h_rsp_gen.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_d2h_rsp_gen_pkg.sv
// ---------------------------------------------------------------------------
// vpu_d2h_rsp_gen_pkg
//   Shared types for the device-to-host completion path: the H2D instruction
//   word as accepted by the decoder, the D2H response payload, the tracker
//   entry kept per outstanding instruction, and the opcode -> write-beat map.
// ---------------------------------------------------------------------------
package vpu_d2h_rsp_gen_pkg;

  localparam int unsigned REQ_FIFO_DEPTH = 16;
  localparam int unsigned EXEC_CNT       = 2;
  localparam int unsigned EXEC_CNT_LG2   = 1;
  localparam int unsigned WB_BEAT_WIDTH  = EXEC_CNT_LG2 + 1;
  localparam int unsigned RSP_TAG_WIDTH  = 8;
  localparam int unsigned OPCODE_WIDTH   = 8;
  localparam int unsigned REG_ADDR_WIDTH = 24;

  typedef logic [OPCODE_WIDTH-1:0] vpu_h2d_req_opcode_t;

  // Elementwise ops occupy 01..0E; FSUM is the only reduction (single beat).
  localparam vpu_h2d_req_opcode_t OP_FIRST = 8'h01;
  localparam vpu_h2d_req_opcode_t OP_LAST  = 8'h0E;
  localparam vpu_h2d_req_opcode_t OP_FSUM  = 8'h06;

  // 128-bit instruction word: opcode + five 24-bit operand fields.
  typedef struct packed {
    vpu_h2d_req_opcode_t       opcode;
    logic [REG_ADDR_WIDTH-1:0] dst0;
    logic [REG_ADDR_WIDTH-1:0] src0;
    logic [REG_ADDR_WIDTH-1:0] src1;
    logic [REG_ADDR_WIDTH-1:0] src2;
    logic [REG_ADDR_WIDTH-1:0] imm;
  } vpu_h2d_req_instr_t;

  typedef enum logic [0:0] {
    RSP_OK         = 1'b0,
    RSP_ILLEGAL_OP = 1'b1
  } vpu_d2h_rsp_status_t;

  typedef struct packed {
    logic [RSP_TAG_WIDTH-1:0]  tag;
    vpu_h2d_req_opcode_t       opcode;
    logic [REG_ADDR_WIDTH-1:0] dst0;
    vpu_d2h_rsp_status_t       status;
  } vpu_d2h_rsp_t;

  // One outstanding instruction as held in the tracker.
  typedef struct packed {
    logic [RSP_TAG_WIDTH-1:0]  tag;
    vpu_h2d_req_opcode_t       opcode;
    logic [REG_ADDR_WIDTH-1:0] dst0;
    logic [WB_BEAT_WIDTH-1:0]  beats;
  } vpu_trk_entry_t;

  // Number of writeback beats an opcode produces; zero marks an illegal opcode.
  function automatic logic [WB_BEAT_WIDTH-1:0] get_wb_beats(input vpu_h2d_req_opcode_t opcode);
    logic [WB_BEAT_WIDTH-1:0] beats;
    if (opcode == OP_FSUM) begin
      beats = WB_BEAT_WIDTH'(1);
    end else if ((opcode >= OP_FIRST) && (opcode <= OP_LAST)) begin
      beats = WB_BEAT_WIDTH'(EXEC_CNT);
    end else begin
      beats = '0;
    end
    return beats;
  endfunction

endpackage

// File: rtl/vpu_sync_fifo.sv
// ---------------------------------------------------------------------------
// vpu_sync_fifo
//   Single-clock FIFO with first-word fall-through read port. Push is ignored
//   when full, pop is ignored when empty; a push and a pop may share a cycle.
// Ports
//   clk, rst        clock, synchronous active-high reset (pointers/count only)
//   push_i, din_i   write request and data
//   pop_i           remove the head entry
//   dout_o          head entry (valid while !empty_o)
//   full_o, empty_o occupancy flags
//   count_o         number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module vpu_sync_fifo #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^AW).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; only entries below count_q are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vpu_d2h_rsp_gen.sv
// ---------------------------------------------------------------------------
// vpu_d2h_rsp_gen
//   Device-to-host completion responder. Every instruction accepted from the
//   decoder is logged with a sequence tag and its expected writeback beat
//   count; once the head instruction has seen all its beats it is retired into
//   a one-deep response register and presented to the host in accept order.
// Ports
//   clk, rst       clock, synchronous active-high reset
//   cmd_valid/_ready/_instr   instruction accepted by the decoder
//   wb_valid/_ready           one SRAM write-port beat from writeback
//   rsp_valid/_ready, rsp     in-order completion {tag, opcode, dst0, status}
//   outstanding               tracker occupancy (held response not counted)
//   err_orphan_wb             sticky flag: beat arrived with nothing tracked
// ---------------------------------------------------------------------------
module vpu_d2h_rsp_gen
  import vpu_d2h_rsp_gen_pkg::*;
#(
  parameter  int unsigned TRK_DEPTH = REQ_FIFO_DEPTH,
  localparam int unsigned TAG_W     = RSP_TAG_WIDTH,
  localparam int unsigned BEAT_W    = WB_BEAT_WIDTH,
  localparam int unsigned OCC_W     = $clog2(TRK_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  vpu_h2d_req_instr_t cmd_instr,
  input  logic               wb_valid,
  output logic               wb_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output vpu_d2h_rsp_t       rsp,
  output logic [OCC_W-1:0]   outstanding,
  output logic               err_orphan_wb
);

  // Per-head phase: no entry, beats still pending, ready to retire.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [BEAT_W-1:0] beat_cnt_q,  beat_cnt_d;
  logic [TAG_W-1:0]  tag_q,       tag_d;
  vpu_d2h_rsp_t      rsp_q,       rsp_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              err_q,       err_d;

  vpu_trk_entry_t    push_entry;
  vpu_trk_entry_t    head;
  logic              trk_push;
  logic              trk_full;
  logic              trk_empty;
  logic [OCC_W-1:0]  trk_count;

  logic [1:0]        phase_c;
  logic              wb_ready_c;
  logic              wb_fire_c;
  logic              complete_c;
  logic              slot_busy_c;
  logic              head_zero_c;
  logic              head_last_c;

  // Operand fields the responder never reports.
  logic              unused_instr_bits;
  assign unused_instr_bits = ^{cmd_instr.src0, cmd_instr.src1, cmd_instr.src2, cmd_instr.imm};

  // Admission depends on full only, so a retiring head never frees a slot early.
  assign cmd_ready = !trk_full;
  assign trk_push  = cmd_valid && !trk_full;

  always_comb begin
    push_entry        = '0;
    push_entry.tag    = tag_q;
    push_entry.opcode = cmd_instr.opcode;
    push_entry.dst0   = cmd_instr.dst0;
    push_entry.beats  = get_wb_beats(cmd_instr.opcode);
  end

  vpu_sync_fifo #(
    .DEPTH (TRK_DEPTH),
    .WIDTH ($bits(vpu_trk_entry_t))
  ) u_trk (
    .clk     (clk),
    .rst     (rst),
    .push_i  (trk_push),
    .din_i   (push_entry),
    .pop_i   (complete_c),
    .dout_o  (head),
    .full_o  (trk_full),
    .empty_o (trk_empty),
    .count_o (trk_count)
  );

  // A held response that the host is not taking this cycle blocks retirement.
  assign slot_busy_c = rsp_valid_q && !rsp_ready;
  assign head_zero_c = (head.beats == '0);
  assign head_last_c = (beat_cnt_q == (head.beats - BEAT_W'(1)));

  // Head phase decode, beat/tag counters and response register next-state.
  always_comb begin
    phase_c     = ST_IDLE;
    wb_ready_c  = 1'b0;
    wb_fire_c   = 1'b0;
    complete_c  = 1'b0;
    beat_cnt_d  = beat_cnt_q;
    tag_d       = tag_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    err_d       = err_q;

    if (!trk_empty) begin
      phase_c = (head_zero_c || head_last_c) ? ST_DONE : ST_COLLECT;
    end

    case (phase_c)
      ST_COLLECT: begin
        wb_ready_c = 1'b1;
      end
      ST_DONE: begin
        // Last beat is only taken when the response slot can absorb it.
        wb_ready_c = !head_zero_c && !slot_busy_c;
        complete_c = !slot_busy_c && (head_zero_c || wb_valid);
      end
      default: begin
        wb_ready_c = 1'b0;
      end
    endcase

    wb_fire_c = wb_valid && wb_ready_c;

    if (trk_push) begin
      tag_d = tag_q + TAG_W'(1);
    end

    if (complete_c) begin
      beat_cnt_d = '0;
    end else if (wb_fire_c) begin
      beat_cnt_d = beat_cnt_q + BEAT_W'(1);
    end

    // Load may coincide with the host draining the previous response.
    if (complete_c) begin
      rsp_valid_d  = 1'b1;
      rsp_d.tag    = head.tag;
      rsp_d.opcode = head.opcode;
      rsp_d.dst0   = head.dst0;
      rsp_d.status = head_zero_c ? RSP_ILLEGAL_OP : RSP_OK;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (wb_valid && trk_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      tag_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      tag_q       <= tag_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  assign wb_ready      = wb_ready_c;
  assign rsp_valid     = rsp_valid_q;
  assign rsp           = rsp_q;
  assign outstanding   = trk_count;
  assign err_orphan_wb = err_q;

endmodule

// File: tb/tb_vpu_d2h_rsp_gen.sv
// ---------------------------------------------------------------------------
// tb_vpu_d2h_rsp_gen
//   Scoreboard bench: each accepted command pushes its expected response; a
//   monitor thread pops and compares whenever a response handshakes, and also
//   checks that a stalled response stays put.
// ---------------------------------------------------------------------------
module tb_vpu_d2h_rsp_gen;
  import vpu_d2h_rsp_gen_pkg::*;

  localparam logic [7:0] OPC_FADD = 8'h01;
  localparam logic [7:0] OPC_FSUB = 8'h02;
  localparam logic [7:0] OPC_FMUL = 8'h03;
  localparam logic [7:0] OPC_FMAX = 8'h05;
  localparam logic [7:0] OPC_FSUM = 8'h06;
  localparam logic [7:0] OPC_BAD  = 8'h3F;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  vpu_h2d_req_instr_t cmd_instr = '0;
  logic               wb_valid = 1'b0;
  logic               wb_ready;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  vpu_d2h_rsp_t       rsp;
  logic [4:0]         outstanding;
  logic               err_orphan_wb;

  int                 n_checks = 0;
  int                 n_errors = 0;
  vpu_d2h_rsp_t       exp_q[$];
  logic [7:0]         exp_tag = 8'd0;
  bit                 done = 1'b0;

  always #5 clk = ~clk;

  vpu_d2h_rsp_gen dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_instr     (cmd_instr),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp           (rsp),
    .outstanding   (outstanding),
    .err_orphan_wb (err_orphan_wb)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one command for one cycle; push the expected response if taken.
  task automatic issue(input logic [7:0] op, input logic [23:0] dst,
                       input vpu_d2h_rsp_status_t st, output bit acc);
    vpu_d2h_rsp_t e;
    cmd_instr        = '0;
    cmd_instr.opcode = op;
    cmd_instr.dst0   = dst;
    cmd_instr.src0   = ~dst;
    cmd_instr.imm    = 24'h5A5A5A;
    cmd_valid        = 1'b1;
    @(negedge clk);
    acc = cmd_ready;
    if (acc) begin
      e.tag    = exp_tag;
      e.opcode = op;
      e.dst0   = dst;
      e.status = st;
      exp_q.push_back(e);
      exp_tag = exp_tag + 8'd1;
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] op, input logic [23:0] dst, input vpu_d2h_rsp_status_t st);
    bit acc;
    issue(op, dst, st, acc);
    check("cmd accept", 64'(acc), 64'(1));
  endtask

  task automatic beat(output bit acc);
    wb_valid = 1'b1;
    @(negedge clk);
    acc = wb_ready;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic beat_exp(input string name, input bit req);
    bit acc;
    beat(acc);
    check(name, 64'(acc), 64'(req));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic monitor();
    vpu_d2h_rsp_t held;
    vpu_d2h_rsp_t e;
    bit           holding = 1'b0;
    held = '0;
    while (!done) begin
      @(negedge clk);
      if (rst) begin
        holding = 1'b0;
      end else begin
        if (holding) begin
          check("rsp hold valid", 64'(rsp_valid), 64'(1));
          check("rsp hold value", 64'(rsp), 64'(held));
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected rsp: got %0h expected none (t=%0t)", rsp, $time);
          end else begin
            e = exp_q.pop_front();
            check("rsp payload", 64'(rsp), 64'(e));
          end
          holding = 1'b0;
        end else if (rsp_valid) begin
          holding = 1'b1;
          held    = rsp;
        end else begin
          holding = 1'b0;
        end
      end
    end
  endtask

  task automatic stimulus();
    bit acc;
    int rej;

    // Reset values
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst wb_ready", 64'(wb_ready), 64'(0));
    check("rst rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst rsp", 64'(rsp), 64'(0));
    check("rst outstanding", 64'(outstanding), 64'(0));
    check("rst err", 64'(err_orphan_wb), 64'(0));
    step();

    // 1: FADD, two beats, response one cycle after the last beat
    rsp_ready = 1'b1;
    send(OPC_FADD, 24'h000123, RSP_OK);
    @(negedge clk);
    check("t1 outstanding", 64'(outstanding), 64'(1));
    check("t1 wb_ready", 64'(wb_ready), 64'(1));
    step();
    beat_exp("t1 beat0", 1'b1);
    @(negedge clk);
    check("t1 no rsp after 1 beat", 64'(rsp_valid), 64'(0));
    step();
    beat_exp("t1 beat1", 1'b1);
    @(negedge clk);
    check("t1 latency rsp_valid", 64'(rsp_valid), 64'(1));
    check("t1 tag", 64'(rsp.tag), 64'(0));
    check("t1 outstanding after", 64'(outstanding), 64'(0));
    step();
    drain("t1 drained");

    // 2: FSUM (1 beat) then FMUL (2 beats), in order
    send(OPC_FSUM, 24'h000010, RSP_OK);
    send(OPC_FMUL, 24'h000011, RSP_OK);
    beat_exp("t2 fsum beat", 1'b1);
    @(negedge clk);
    check("t2 fsum rsp_valid", 64'(rsp_valid), 64'(1));
    check("t2 fsum opcode", 64'(rsp.opcode), 64'(OPC_FSUM));
    check("t2 outstanding", 64'(outstanding), 64'(1));
    step();
    beat_exp("t2 fmul beat0", 1'b1);
    beat_exp("t2 fmul beat1", 1'b1);
    drain("t2 drained");

    // 3: illegal opcode retires with no beats; wb_ready low while at head
    send(OPC_BAD, 24'h000020, RSP_ILLEGAL_OP);
    wb_valid = 1'b1;
    @(negedge clk);
    check("t3 wb_ready", 64'(wb_ready), 64'(0));
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    check("t3 rsp_valid", 64'(rsp_valid), 64'(1));
    check("t3 status", 64'(rsp.status), 64'(RSP_ILLEGAL_OP));
    check("t3 outstanding", 64'(outstanding), 64'(0));
    step();
    drain("t3 drained");
    check("t3 no orphan", 64'(err_orphan_wb), 64'(0));

    // 4: host stalls; second last beat is held off until the slot drains
    rsp_ready = 1'b0;
    send(OPC_FADD, 24'h00004A, RSP_OK);
    send(OPC_FSUB, 24'h00004B, RSP_OK);
    beat_exp("t4 A beat0", 1'b1);
    beat_exp("t4 A beat1", 1'b1);
    beat_exp("t4 B beat0", 1'b1);
    for (int i = 0; i < 3; i++) begin
      beat_exp("t4 B last stalled", 1'b0);
    end
    @(negedge clk);
    check("t4 held valid", 64'(rsp_valid), 64'(1));
    check("t4 held dst", 64'(rsp.dst0), 64'(24'h00004A));
    step();
    rsp_ready = 1'b1;
    wb_valid  = 1'b1;
    @(negedge clk);
    check("t4 release wb_ready", 64'(wb_ready), 64'(1));
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    check("t4 back-to-back valid", 64'(rsp_valid), 64'(1));
    check("t4 back-to-back dst", 64'(rsp.dst0), 64'(24'h00004B));
    step();
    @(negedge clk);
    check("t4 slot empty", 64'(rsp_valid), 64'(0));
    step();
    drain("t4 drained");

    // 5: fill tracker; push refused at full even with a same-cycle pop
    for (int i = 0; i < 16; i++) begin
      send(OPC_FADD, 24'(i + 256), RSP_OK);
    end
    @(negedge clk);
    check("t5 outstanding full", 64'(outstanding), 64'(16));
    check("t5 cmd_ready full", 64'(cmd_ready), 64'(0));
    step();
    issue(OPC_FMAX, 24'h000999, RSP_OK, acc);
    check("t5 push at full refused", 64'(acc), 64'(0));
    beat_exp("t5 head beat0", 1'b1);
    cmd_instr        = '0;
    cmd_instr.opcode = OPC_FMAX;
    cmd_instr.dst0   = 24'h000998;
    cmd_valid        = 1'b1;
    wb_valid         = 1'b1;
    @(negedge clk);
    check("t5 push+pop cmd_ready", 64'(cmd_ready), 64'(0));
    check("t5 push+pop wb_ready", 64'(wb_ready), 64'(1));
    step();
    cmd_valid = 1'b0;
    wb_valid  = 1'b0;
    @(negedge clk);
    check("t5 outstanding after pop", 64'(outstanding), 64'(15));
    step();
    rej = 0;
    for (int i = 0; i < 30; i++) begin
      beat(acc);
      if (!acc) rej++;
    end
    check("t5 drain beats refused", 64'(rej), 64'(0));
    drain("t5 drained");
    check("t5 outstanding empty", 64'(outstanding), 64'(0));

    // 5b: tag wrap FF -> 00 using zero-beat commands
    for (int i = 0; i < 250; i++) begin
      send(OPC_BAD, 24'(i), RSP_ILLEGAL_OP);
    end
    drain("t5 wrap drained");

    // 6: orphan beat is sticky
    @(negedge clk);
    check("t6 err before", 64'(err_orphan_wb), 64'(0));
    step();
    wb_valid = 1'b1;
    @(negedge clk);
    check("t6 orphan wb_ready", 64'(wb_ready), 64'(0));
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    check("t6 err set", 64'(err_orphan_wb), 64'(1));
    step();
    repeat (3) step();
    send(OPC_FADD, 24'h000600, RSP_OK);
    @(negedge clk);
    check("t6 err sticky", 64'(err_orphan_wb), 64'(1));
    step();
    beat_exp("t6 beat0", 1'b1);
    beat_exp("t6 beat1", 1'b1);
    drain("t6 drained");

    // 6b: reset with a held response and a half-collected head
    rsp_ready = 1'b0;
    send(OPC_FADD, 24'h000700, RSP_OK);
    beat_exp("t6 X beat0", 1'b1);
    beat_exp("t6 X beat1", 1'b1);
    send(OPC_FADD, 24'h000701, RSP_OK);
    beat_exp("t6 Y beat0", 1'b1);
    rst = 1'b1;
    exp_q.delete();
    exp_tag = 8'd0;
    step();
    @(negedge clk);
    check("t6 rst rsp_valid", 64'(rsp_valid), 64'(0));
    check("t6 rst rsp", 64'(rsp), 64'(0));
    check("t6 rst outstanding", 64'(outstanding), 64'(0));
    check("t6 rst cmd_ready", 64'(cmd_ready), 64'(1));
    check("t6 rst wb_ready", 64'(wb_ready), 64'(0));
    check("t6 rst err", 64'(err_orphan_wb), 64'(0));
    step();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    check("t6 no stale rsp", 64'(rsp_valid), 64'(0));
    step();
    send(OPC_FADD, 24'h000800, RSP_OK);
    beat_exp("t6 post beat0", 1'b1);
    beat_exp("t6 post beat1", 1'b1);
    drain("t6 post drained");
    repeat (3) step();
  endtask

  initial begin
    fork
      monitor();
      begin
        stimulus();
        done = 1'b1;
      end
    join
    check("scoreboard leftover", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
